board_gpio_frontend: RTL and testbench

Parametrised board-side GPIO front end between the FPGA switch/LED pads and the SoC GPIO port. It replaces the fixed inverting wiring of switches and LEDs at board top level. Switch inputs are synchronised, debounced and polarity-corrected, and change-event flags are captured for them. LED outputs are gated by write-enable, dimmed by a global PWM, polarity-corrected and registered. One instance sits in each board top level, between the pads and the SoC `io_gpioA_*` bus.

---
 rtl/board_gpio_frontend.sv | 108 ++++++++++
 tb/tb_board_gpio_frontend.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/board_gpio_frontend.sv
module board_gpio_frontend #(
  parameter int N_SW           = 8,
  parameter int N_LED          = 14,
  parameter int SW_ACTIVE_LOW  = 1,
  parameter int LED_ACTIVE_LOW = 1,
  parameter int TICK_DIV       = 1000,
  parameter int DB_TICKS       = 10,
  parameter int PWM_BITS       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_SW-1:0]     sw_pad,
  output logic [N_SW-1:0]     gpio_read,
  output logic [N_SW-1:0]     sw_event,
  input  logic [N_SW-1:0]     sw_event_clr,
  input  logic [N_LED-1:0]    gpio_write,
  input  logic [N_LED-1:0]    gpio_write_en,
  input  logic [PWM_BITS:0]   led_brightness,
  output logic [N_LED-1:0]    led_pad,
  output logic                debounce_tick
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int DB_W   = $clog2(DB_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DB_TICKS - 1);
  localparam logic [PWM_BITS:0] BRIGHT_FULL = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [N_SW-1:0]   SW_POL      = (SW_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [N_LED-1:0]  LED_POL     = (LED_ACTIVE_LOW != 0) ? '1 : '0;

  // Synchroniser flops hold the polarity-corrected level, so resetting them
  // to '0 is the same as resetting to the inactive pad level.
  logic [N_SW-1:0]     sync1_q, sync1_d;
  logic [N_SW-1:0]     sync2_q, sync2_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [DB_W-1:0]     db_cnt_q [N_SW];
  logic [DB_W-1:0]     db_cnt_d [N_SW];
  logic [N_SW-1:0]     read_q, read_d;
  logic [N_SW-1:0]     event_q, event_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS:0]   bright_q, bright_d;
  logic [N_LED-1:0]    led_q, led_d;
  logic                tick;
  logic                pwm_on;

  always_comb begin
    sync1_d    = sw_pad ^ SW_POL;
    sync2_d    = sync1_q;

    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    read_d     = read_q;
    event_d    = event_q & ~sw_event_clr;
    db_cnt_d   = db_cnt_q;
    for (int unsigned i = 0; i < N_SW; i++) begin
      if (sync2_q[i] == read_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (tick) begin
        if (db_cnt_q[i] == DB_LAST) begin
          read_d[i]   = ~read_q[i];
          db_cnt_d[i] = '0;
          event_d[i]  = 1'b1;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end

    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    bright_d   = (&pwm_cnt_q) ? led_brightness : bright_q;
    pwm_on     = ({1'b0, pwm_cnt_q} < bright_q);
    led_d      = LED_POL ^ (gpio_write & gpio_write_en & {N_LED{pwm_on}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
      for (int unsigned i = 0; i < N_SW; i++) begin
        db_cnt_q[i] <= '0;
      end
      read_q     <= '0;
      event_q    <= '0;
      pwm_cnt_q  <= '0;
      bright_q   <= BRIGHT_FULL;
      led_q      <= LED_POL;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tick_cnt_q <= tick_cnt_d;
      db_cnt_q   <= db_cnt_d;
      read_q     <= read_d;
      event_q    <= event_d;
      pwm_cnt_q  <= pwm_cnt_d;
      bright_q   <= bright_d;
      led_q      <= led_d;
    end
  end

  assign gpio_read     = read_q;
  assign sw_event      = event_q;
  assign led_pad       = led_q;
  assign debounce_tick = tick;

endmodule

// File: tb/tb_board_gpio_frontend.sv
`timescale 1ns/1ps
module tb_board_gpio_frontend;

  localparam int TB_TICK_DIV = 4;
  localparam int TB_DB_TICKS = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw_pad;
  logic [3:0] gpio_read;
  logic [3:0] sw_event;
  logic [3:0] sw_event_clr;
  logic [3:0] gpio_write;
  logic [3:0] gpio_write_en;
  logic [2:0] led_brightness;
  logic [3:0] led_pad;
  logic       debounce_tick;

  always #5 clk = ~clk;

  board_gpio_frontend #(
    .N_SW          (4),
    .N_LED         (4),
    .SW_ACTIVE_LOW (1),
    .LED_ACTIVE_LOW(1),
    .TICK_DIV      (TB_TICK_DIV),
    .DB_TICKS      (TB_DB_TICKS),
    .PWM_BITS      (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sw_pad        (sw_pad),
    .gpio_read     (gpio_read),
    .sw_event      (sw_event),
    .sw_event_clr  (sw_event_clr),
    .gpio_write    (gpio_write),
    .gpio_write_en (gpio_write_en),
    .led_brightness(led_brightness),
    .led_pad       (led_pad),
    .debounce_tick (debounce_tick)
  );

  // Rising edges since the last reset release; prescaler and PWM phase follow it.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edge on which gpio_read toggles for a pad change driven when cyc == c0.
  function automatic int toggle_cyc(input int c0);
    int n = 0;
    for (int p = c0 + 3; p < c0 + 100; p++) begin
      if (p % TB_TICK_DIV == 0) begin
        n++;
        if (n == TB_DB_TICKS) return p;
      end
    end
    return -1;
  endfunction

  logic [11:0] vec12;
  logic [7:0]  vec8;
  logic        seen_read, seen_ev;
  int          c0, p, lat, guard;

  initial begin
    rst_n          = 1'b0;
    sw_pad         = 4'hF;
    sw_event_clr   = 4'h0;
    gpio_write     = 4'h0;
    gpio_write_en  = 4'h0;
    led_brightness = 3'd4;
    repeat (3) @(negedge clk);
    check("rst_led",   led_pad,       4'hF);
    check("rst_read",  gpio_read,     4'h0);
    check("rst_event", sw_event,      4'h0);
    check("rst_tick",  debounce_tick, 1'b0);
    rst_n = 1'b1;

    // Prescaler: tick high whenever tick_cnt == 3
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      vec12[j] = debounce_tick;
    end
    check("tick_period", vec12, 12'h444);

    // Clean press of switch 0
    @(negedge clk);
    sw_pad[0] = 1'b0;
    c0  = cyc;
    p   = toggle_cyc(c0);
    lat = 40;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (gpio_read[0]) begin
        lat = k;
        break;
      end
    end
    check("press_lat",    lat, p - c0);
    check("press_window", (lat >= 10 && lat <= 14), 1'b1);
    check("press_read",   gpio_read, 4'b0001);
    check("press_event",  sw_event,  4'b0001);

    // Glitch of 7 cycles on switch 1
    seen_read = 1'b0;
    seen_ev   = 1'b0;
    @(negedge clk);
    sw_pad[1] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 6) sw_pad[1] = 1'b1;
      seen_read |= gpio_read[1];
      seen_ev   |= sw_event[1];
    end
    check("glitch_read",  seen_read, 1'b0);
    check("glitch_event", seen_ev,   1'b0);
    check("glitch_keep0", gpio_read, 4'b0001);

    // Lone clear, then clear colliding with a debounced release
    sw_event_clr = 4'b0001;
    @(negedge clk);
    sw_event_clr = 4'b0000;
    check("clr_lone1", sw_event, 4'b0000);
    sw_pad[0] = 1'b1;
    c0 = cyc;
    p  = toggle_cyc(c0);
    guard = 0;
    while (cyc != p - 1 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    sw_event_clr = 4'b0001;
    @(negedge clk);
    sw_event_clr = 4'b0000;
    check("coll_cycle", cyc, p);
    check("coll_read",  gpio_read, 4'b0000);
    check("coll_event", sw_event,  4'b0001);
    repeat (3) @(negedge clk);
    check("coll_hold", sw_event, 4'b0001);
    sw_event_clr = 4'b0001;
    @(negedge clk);
    sw_event_clr = 4'b0000;
    check("clr_lone2", sw_event, 4'b0000);

    // LED gating at full brightness
    gpio_write    = 4'b1010;
    gpio_write_en = 4'b0011;
    @(negedge clk);
    check("led_gate", led_pad, 4'b1101);

    // PWM duty 1/4, then 3/4 from the following period
    gpio_write     = 4'b0001;
    gpio_write_en  = 4'b0001;
    led_brightness = 3'd1;
    @(negedge clk);
    guard = 0;
    while (cyc % 4 != 0 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      vec12[j] = led_pad[0];
      if (j == 4) led_brightness = 3'd3;
    end
    check("pwm_duty", vec12, 12'h8EE);
    check("pwm_others", led_pad[3:1], 3'b111);

    // Zero brightness keeps LED off
    led_brightness = 3'd0;
    @(negedge clk);
    guard = 0;
    while (cyc % 4 != 0 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      vec8[j] = led_pad[0];
    end
    check("pwm_zero", vec8, 8'hFF);

    // Asynchronous reset mid-operation
    led_brightness = 3'd4;
    gpio_write     = 4'hF;
    gpio_write_en  = 4'hF;
    sw_pad         = 4'b1011;
    repeat (20) @(negedge clk);
    check("pre_rst_led",   led_pad,   4'h0);
    check("pre_rst_read",  gpio_read, 4'b0100);
    check("pre_rst_event", sw_event,  4'b0100);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_led",   led_pad,       4'hF);
    check("mid_rst_read",  gpio_read,     4'h0);
    check("mid_rst_event", sw_event,      4'h0);
    check("mid_rst_tick",  debounce_tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
